// File: rtl/utf_pkg.sv
// Shared constants and state type for the UTF-16 encoder slice.
package utf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01
  } state_t;

  localparam logic [15:0] SURR_HI_BASE = 16'hD800;
  localparam logic [15:0] SURR_LO_BASE = 16'hDC00;
  localparam logic [31:0] SUPP_BASE    = 32'h10000;
  localparam logic [31:0] MAX_CP       = 32'h10FFFF;
  localparam logic [15:0] REPL_CHAR    = 16'hFFFD;

endpackage

// File: rtl/utf16_cp_classify.sv
// Combinational classifier: flags code points that cannot be encoded and
// those that need a surrogate pair.
module utf16_cp_classify
  import utf_pkg::*;
(
  input  logic [31:0] cp_in,
  input  logic        cp_err,
  output logic        reject,
  output logic        is_supp
);

  logic is_surrogate;

  // Surrogate halves are never valid scalar values on their own.
  assign is_surrogate = (cp_in >= {16'h0000, SURR_HI_BASE}) &&
                        (cp_in <= {16'h0000, SURR_LO_BASE | 16'h03FF});

  assign reject  = cp_err || (cp_in > MAX_CP) || is_surrogate;
  assign is_supp = (cp_in >= SUPP_BASE);

endmodule

// File: rtl/utf16_encoder.sv
// Code point to UTF-16 encoder with ready/valid ports on both sides.
// Define UTF16_REPLACE_EN to emit REPL for rejected characters.
module utf16_encoder
  import utf_pkg::*;
#(
  parameter int          CNT_W = 16,
  parameter logic [15:0] REPL  = REPL_CHAR
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cp_in,
  input  logic             cp_err,
  input  logic             cp_valid,
  output logic             cp_ready,
  output logic [15:0]      u16_out,
  output logic             u16_last,
  output logic             u16_valid,
  input  logic             u16_ready,
  output logic             err,
  output logic [CNT_W-1:0] char_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           state, state_n;
  logic [15:0]      lo_unit, lo_unit_n;
  logic [15:0]      out_n;
  logic             last_n, valid_n, err_n;
  logic [CNT_W-1:0] char_cnt_n, err_cnt_n;
  logic             reject, is_supp, accept;
  logic [19:0]      supp_off;

  utf16_cp_classify u_classify (
    .cp_in   (cp_in),
    .cp_err  (cp_err),
    .reject  (reject),
    .is_supp (is_supp)
  );

  assign cp_ready = !rst && (state == IDLE) && (!u16_valid || u16_ready);
  assign accept   = cp_valid && cp_ready;
  assign supp_off = 20'(cp_in - SUPP_BASE);

  always_comb begin
    state_n    = state;
    lo_unit_n  = lo_unit;
    out_n      = u16_out;
    last_n     = u16_last;
    valid_n    = u16_valid && !u16_ready;
    err_n      = 1'b0;
    char_cnt_n = char_cnt;
    err_cnt_n  = err_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            err_n     = 1'b1;
            err_cnt_n = err_cnt + CNT_W'(1);
`ifdef UTF16_REPLACE_EN
            out_n     = REPL;
            last_n    = 1'b1;
            valid_n   = 1'b1;
`else
            // Accept implies the output register is free, so this stays invisible.
            out_n     = REPL;
            last_n    = 1'b0;
`endif
          end else if (is_supp) begin
            out_n      = SURR_HI_BASE | {6'b0, supp_off[19:10]};
            lo_unit_n  = SURR_LO_BASE | {6'b0, supp_off[9:0]};
            last_n     = 1'b0;
            valid_n    = 1'b1;
            state_n    = LOW;
            char_cnt_n = char_cnt + CNT_W'(1);
          end else begin
            out_n      = cp_in[15:0];
            last_n     = 1'b1;
            valid_n    = 1'b1;
            char_cnt_n = char_cnt + CNT_W'(1);
          end
        end
      end
      LOW: begin
        // The high surrogate is always on the bus here; swap in the low half.
        if (u16_valid && u16_ready) begin
          out_n     = lo_unit;
          last_n    = 1'b1;
          valid_n   = 1'b1;
          lo_unit_n = 16'h0000;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lo_unit   <= 16'h0000;
      u16_out   <= 16'h0000;
      u16_last  <= 1'b0;
      u16_valid <= 1'b0;
      err       <= 1'b0;
      char_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      lo_unit   <= lo_unit_n;
      u16_out   <= out_n;
      u16_last  <= last_n;
      u16_valid <= valid_n;
      err       <= err_n;
      char_cnt  <= char_cnt_n;
      err_cnt   <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_utf16_encoder.sv
// Self-checking bench for utf16_encoder: queue-based reference model checked
// every cycle, directed cases with literal expectations, then random traffic.
module tb_utf16_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cp_in = 32'h0;
  logic        cp_err = 1'b0;
  logic        cp_valid = 1'b0;
  logic        cp_ready;
  logic [15:0] u16_out;
  logic        u16_last;
  logic        u16_valid;
  logic        u16_ready = 1'b1;
  logic        err;
  logic [15:0] char_cnt;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;

  // Reference model: queue of units still owed downstream, head is on the bus.
  logic [16:0] exp_q[$];
  logic        exp_err_next = 1'b0;
  logic [15:0] m_char_cnt = 16'h0;
  logic [15:0] m_err_cnt = 16'h0;

  utf16_encoder #(.CNT_W(16), .REPL(16'hFFFD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cp_in     (cp_in),
    .cp_err    (cp_err),
    .cp_valid  (cp_valid),
    .cp_ready  (cp_ready),
    .u16_out   (u16_out),
    .u16_last  (u16_last),
    .u16_valid (u16_valid),
    .u16_ready (u16_ready),
    .err       (err),
    .char_cnt  (char_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [31:0] cp, input logic e);
    logic [31:0] v;
    if (e || cp > 32'h10FFFF || (cp >= 32'hD800 && cp < 32'hE000)) begin
      exp_err_next = 1'b1;
      m_err_cnt = m_err_cnt + 16'd1;
`ifdef UTF16_REPLACE_EN
      exp_q.push_back({1'b1, 16'hFFFD});
`endif
    end else if (cp < 32'h10000) begin
      exp_q.push_back({1'b1, cp[15:0]});
      m_char_cnt = m_char_cnt + 16'd1;
    end else begin
      v = cp - 32'h10000;
      exp_q.push_back({1'b0, 16'(32'hD800 + v / 1024)});
      exp_q.push_back({1'b1, 16'(32'hDC00 + v % 1024)});
      m_char_cnt = m_char_cnt + 16'd1;
    end
  endtask

  // Compare process: check the state left by the last edge, then advance the
  // model using the inputs that the coming edge will sample.
  always @(negedge clk) begin
    logic rdy_exp;
    if (mon_en) begin
      rdy_exp = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && u16_ready));
      checkOutput("mon_valid", {31'b0, u16_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0)
        checkOutput("mon_unit", {15'b0, u16_last, u16_out}, {15'b0, exp_q[0]});
      checkOutput("mon_cp_ready", {31'b0, cp_ready}, {31'b0, rdy_exp});
      checkOutput("mon_err", {31'b0, err}, {31'b0, exp_err_next});
      checkOutput("mon_char_cnt", {16'b0, char_cnt}, {16'b0, m_char_cnt});
      checkOutput("mon_err_cnt", {16'b0, err_cnt}, {16'b0, m_err_cnt});
      exp_err_next = 1'b0;
      if (rst) begin
        exp_q.delete();
        m_char_cnt = 16'h0;
        m_err_cnt = 16'h0;
      end else begin
        if (exp_q.size() != 0 && u16_ready) void'(exp_q.pop_front());
        if (cp_valid && rdy_exp) model_accept(cp_in, cp_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) u16_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(input logic [31:0] cp, input logic e);
    bit done = 1'b0;
    cp_in = cp;
    cp_err = e;
    cp_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (cp_ready) done = 1'b1;
      tick();
    end
    if (!done) checkOutput("cp_accept_timeout", 32'd0, 32'd1);
    cp_valid = 1'b0;
    cp_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("cp_ready_in_reset", {31'b0, cp_ready}, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] cp;
    int kind;
    tick();
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_valid", {31'b0, u16_valid}, 32'd0);
    checkOutput("reset_out", {16'b0, u16_out}, 32'h0);
    checkOutput("reset_last", {31'b0, u16_last}, 32'd0);
    checkOutput("reset_char_cnt", {16'b0, char_cnt}, 32'd0);
    checkOutput("reset_err_cnt", {16'b0, err_cnt}, 32'd0);
    tick();
    rst = 1'b0;

    // Single BMP character
    applyStimulus(32'h41, 1'b0);
    @(negedge clk);
    checkOutput("bmp_out", {16'b0, u16_out}, 32'h0041);
    checkOutput("bmp_last", {31'b0, u16_last}, 32'd1);
    checkOutput("bmp_char_cnt", {16'b0, char_cnt}, 32'd1);
    tick();

    // Supplementary character, free-flowing output
    applyStimulus(32'h1F600, 1'b0);
    @(negedge clk);
    checkOutput("supp_hi", {15'b0, u16_last, u16_out}, {15'b0, 1'b0, 16'hD83D});
    checkOutput("supp_cp_ready_low", {31'b0, cp_ready}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("supp_lo", {15'b0, u16_last, u16_out}, {15'b0, 1'b1, 16'hDE00});
    tick();

    // Supplementary character with a 3-cycle downstream stall
    u16_ready = 1'b0;
    applyStimulus(32'h1F600, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_hi", {15'b0, u16_valid, u16_out}, {15'b0, 1'b1, 16'hD83D});
      if (i == 2) u16_ready = 1'b1;
      else tick();
    end
    tick();
    @(negedge clk);
    checkOutput("stall_lo", {15'b0, u16_last, u16_out}, {15'b0, 1'b1, 16'hDE00});
    tick();
    tick();

    // Rejected characters from a clean reset
    do_reset();
    applyStimulus(32'hD800, 1'b0);
    @(negedge clk);
    checkOutput("rej1_err", {31'b0, err}, 32'd1);
    tick();
    applyStimulus(32'h110000, 1'b0);
    @(negedge clk);
    checkOutput("rej2_err", {31'b0, err}, 32'd1);
    checkOutput("rej_err_cnt", {16'b0, err_cnt}, 32'd2);
`ifdef UTF16_REPLACE_EN
    checkOutput("rej_repl", {16'b0, u16_out}, 32'hFFFD);
`else
    checkOutput("rej_no_valid", {31'b0, u16_valid}, 32'd0);
`endif
    tick();
    tick();

    // Reset while the high surrogate is presented
    do_reset();
    applyStimulus(32'h10000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_hi_presented", {16'b0, u16_out}, 32'hD800);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_drop_valid", {31'b0, u16_valid}, 32'd0);
    checkOutput("rst_char_cnt", {16'b0, char_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      checkOutput("rst_no_lo", {31'b0, u16_valid}, 32'd0);
    end
    tick();

    // Back-to-back BMP characters, one unit per cycle
    cp_in = 32'h41;
    cp_valid = 1'b1;
    @(negedge clk);
    tick();
    cp_in = 32'h42;
    @(negedge clk);
    checkOutput("b2b_0", {16'b0, u16_out}, 32'h41);
    tick();
    cp_in = 32'h43;
    @(negedge clk);
    checkOutput("b2b_1", {16'b0, u16_out}, 32'h42);
    tick();
    cp_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_2", {15'b0, u16_valid, u16_out}, {15'b0, 1'b1, 16'h43});
    tick();

    // Random traffic with random downstream backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: cp = $urandom_range(0, 32'hD7FF);
        3:       cp = $urandom_range(32'hE000, 32'hFFFF);
        4:       cp = $urandom_range(32'hD800, 32'hDFFF);
        5, 6, 7: cp = $urandom_range(32'h10000, 32'h10FFFF);
        8:       cp = $urandom_range(32'h110000, 32'hFFFFFFFF);
        default: cp = $urandom;
      endcase
      applyStimulus(cp, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 1'b0;
    u16_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    checkOutput("drain_empty", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
